conv_bram_1d_result_rd: RTL and testbench

CONV_BRAM_1D_RESULT_RD -- requirements
Module: conv_bram_1d_result_rd

---
 rtl/conv_bram_1d_result_rd.sv | 141 ++++++++++++++
 tb/tb_conv_bram_1d_result_rd.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_bram_1d_result_rd.sv
// rtl/conv_bram_1d_result_rd.sv - drains one convolution result frame from RESULT_D banks as column beats
// Optional build macro: CONV_RESULT_RD_RELU_EN (zero negative lanes at the buffer input).
module conv_bram_1d_result_rd #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 32,
  parameter int FILTER_L   = 3,
  parameter int RESULT_D   = 4,
  parameter int STRIDE_W   = 1,
  localparam int RESULT_W  = (IMG_W - FILTER_L) / STRIDE_W + 1,
  // A single-entry bank still needs a 1-bit address bus.
  localparam int RESULT_RAM_ADDR_WIDTH = (RESULT_W > 1) ? $clog2(RESULT_W) : 1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      val_in,
  output logic                                      rdy_in,
  output logic [RESULT_RAM_ADDR_WIDTH*RESULT_D-1:0] result_rdaddr,
  input  logic [DATA_WIDTH*RESULT_D-1:0]            result_rddata,
  output logic [RESULT_D-1:0]                       result_rden,
  output logic [DATA_WIDTH*RESULT_D-1:0]            out_data,
  output logic                                      out_val,
  input  logic                                      out_rdy,
  output logic                                      out_last
);

  localparam int AW = RESULT_RAM_ADDR_WIDTH;
  localparam int CW = DATA_WIDTH * RESULT_D;
  localparam logic [AW-1:0] LAST_ADDR = AW'(RESULT_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] addr_cnt;
  logic [AW-1:0] last_addr;
  logic          rd_pend;
  logic          rd_pend_last;
  logic [1:0]    count;
  logic [CW-1:0] head_data;
  logic [CW-1:0] tail_data;
  logic          head_last;
  logic          tail_last;

  logic          issue;
  logic          pop;
  logic          push;
  logic [2:0]    committed;
  logic [CW-1:0] push_data;

  // Credit check counts the head slot freed by a same-cycle pop, which is
  // what lets a 2-entry buffer sustain one beat per cycle.
  always_comb begin
    pop       = (count != 2'd0) && out_rdy;
    push      = rd_pend;
    committed = {1'b0, count} + {2'b0, rd_pend} - {2'b0, pop};
    issue     = (state == S_READ) && (committed < 3'd2);
  end

  always_comb begin
    push_data = result_rddata;
`ifdef CONV_RESULT_RD_RELU_EN
    for (int i = 0; i < RESULT_D; i++) begin
      if (result_rddata[i*DATA_WIDTH + DATA_WIDTH-1])
        push_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
`endif
  end

  assign rdy_in        = (state == S_IDLE);
  assign out_val       = (count != 2'd0);
  assign out_data      = head_data;
  assign out_last      = head_last && (count != 2'd0);
  assign result_rden   = {RESULT_D{issue}};
  assign result_rdaddr = {RESULT_D{issue ? addr_cnt : last_addr}};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      addr_cnt     <= '0;
      last_addr    <= '0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      count        <= 2'd0;
      head_data    <= '0;
      tail_data    <= '0;
      head_last    <= 1'b0;
      tail_last    <= 1'b0;
    end else begin
      rd_pend      <= issue;
      rd_pend_last <= issue && (addr_cnt == LAST_ADDR);

      case (state)
        S_IDLE: begin
          if (val_in) begin
            state    <= S_READ;
            addr_cnt <= '0;
          end
        end
        S_READ: begin
          if (issue) begin
            last_addr <= addr_cnt;
            if (addr_cnt == LAST_ADDR) state <= S_DRAIN;
            else                       addr_cnt <= addr_cnt + AW'(1);
          end
        end
        S_DRAIN: begin
          if (pop && head_last) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Head register drives the outputs directly and only moves on a pop.
      if (push && !pop) begin
        if (count == 2'd0) begin
          head_data <= push_data;
          head_last <= rd_pend_last;
        end else begin
          tail_data <= push_data;
          tail_last <= rd_pend_last;
        end
        count <= count + 2'd1;
      end else if (!push && pop) begin
        head_data <= tail_data;
        head_last <= tail_last;
        count     <= count - 2'd1;
      end else if (push && pop) begin
        if (count == 2'd1) begin
          head_data <= push_data;
          head_last <= rd_pend_last;
        end else begin
          head_data <= tail_data;
          head_last <= tail_last;
          tail_data <= push_data;
          tail_last <= rd_pend_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_bram_1d_result_rd.sv
// tb/tb_conv_bram_1d_result_rd.sv - directed bench for conv_bram_1d_result_rd with default parameters
// Honors CONV_RESULT_RD_RELU_EN in its expected-value model.
module tb_conv_bram_1d_result_rd;

  logic        clk = 1'b0;
  logic        reset;
  logic        val_in;
  logic        rdy_in;
  logic [19:0] result_rdaddr;
  logic [31:0] result_rddata;
  logic [3:0]  result_rden;
  logic [31:0] out_data;
  logic        out_val;
  logic        out_rdy;
  logic        out_last;

  logic [7:0]  mem [4][32];
  logic [31:0] col5;
  int          vectors;
  int          miscompares;

  always #5 clk = ~clk;

  conv_bram_1d_result_rd dut (
    .clk(clk), .reset(reset), .val_in(val_in), .rdy_in(rdy_in),
    .result_rdaddr(result_rdaddr), .result_rddata(result_rddata), .result_rden(result_rden),
    .out_data(out_data), .out_val(out_val), .out_rdy(out_rdy), .out_last(out_last)
  );

  // Banks: registered read, data valid the cycle after the address.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (result_rden[i]) result_rddata[i*8 +: 8] <= mem[i][result_rdaddr[i*5 +: 5]];
  end

  function automatic logic [31:0] exp_col(input int a);
    logic [31:0] r;
    logic [7:0]  v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      v = mem[i][a];
`ifdef CONV_RESULT_RD_RELU_EN
      if (v[7]) v = 8'h00;
`endif
      r[i*8 +: 8] = v;
    end
    return r;
  endfunction

  task automatic tick(input logic rdy, input logic v, input logic rs);
    @(negedge clk);
    out_rdy = rdy;
    val_in  = v;
    reset   = rs;
    #1;
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    vectors++;
    if ({rdy_in, out_val, out_last} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_flags: got rdy/val/last=%b expected 100", {rdy_in, out_val, out_last});
    end
    vectors++;
    if (result_rden !== 4'h0 || result_rdaddr !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_rd: got rden=%h addr=%h expected 0/0", result_rden, result_rdaddr);
    end
    vectors++;
    if (out_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h expected 0", out_data);
    end
  endtask

  // mode 0: out_rdy high, 1: out_rdy 1,0,0,1 pattern, 2: stalled 20 cycles, 3: val_in pulses mid-frame
  task automatic test_frame(input string name, input int mode);
    int          beat;
    int          rd_next;
    bit          done;
    logic        rdy;
    logic        v;
    logic        pv, pr, pl;
    logic [31:0] pd;
    logic [4:0]  ra;
    tick(1'b1, 1'b0, 1'b1);
    vectors++;
    if (rdy_in !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_idle_rdy: got %b expected 1", name, rdy_in);
    end
    tick(mode == 2 ? 1'b0 : 1'b1, 1'b1, 1'b1);
    beat = 0; rd_next = 0; done = 0;
    pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = '0;
    for (int cyc = 1; cyc < 600 && !done; cyc++) begin
      rdy = (mode == 1) ? (((cyc-1) % 4 == 0) || ((cyc-1) % 4 == 3)) :
            (mode == 2) ? (cyc > 20) : 1'b1;
      v   = (mode == 3) && (cyc % 3 == 0);
      tick(rdy, v, 1'b1);
      vectors++;
      if (rdy_in !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_busy_rdy cyc %0d: got %b expected 0", name, cyc, rdy_in);
      end
      if (mode == 0 && (cyc == 2 || cyc == 3)) begin
        vectors++;
        if (out_val !== (cyc == 3)) begin
          miscompares++;
          $display("FAIL %s_latency cyc %0d: got out_val=%b expected %b", name, cyc, out_val, cyc == 3);
        end
      end
      if (result_rden !== 4'h0) begin
        ra = rd_next[4:0];
        vectors++;
        if (result_rden !== 4'hF || result_rdaddr !== {4{ra}} || rd_next > 29) begin
          miscompares++;
          $display("FAIL %s_rdaddr: got rden=%h addr=%h expected F/%h", name, result_rden, result_rdaddr, {4{ra}});
        end
        rd_next++;
      end
      if (mode == 2 && cyc == 20) begin
        vectors++;
        if (rd_next > 2 || out_val !== 1'b1 || out_data !== exp_col(0)) begin
          miscompares++;
          $display("FAIL %s_stall: got reads=%0d val=%b data=%h expected <=2/1/%h", name, rd_next, out_val, out_data, exp_col(0));
        end
      end
      if (pv && !pr) begin
        vectors++;
        if (out_val !== 1'b1 || out_last !== pl || out_data !== pd) begin
          miscompares++;
          $display("FAIL %s_hold: got val=%b last=%b data=%h expected 1/%b/%h", name, out_val, out_last, out_data, pl, pd);
        end
      end
      if (out_val && out_rdy) begin
        vectors++;
        if (out_data !== exp_col(beat) || out_last !== (beat == 29)) begin
          miscompares++;
          $display("FAIL %s_beat %0d: got data=%h last=%b expected %h/%b", name, beat, out_data, out_last, exp_col(beat), beat == 29);
        end
        if (beat == 5) col5 = out_data;
        if (out_last) done = 1;
        beat++;
      end
      pv = out_val; pr = out_rdy; pl = out_last; pd = out_data;
    end
    vectors++;
    if (!done || beat != 30 || rd_next != 30) begin
      miscompares++;
      $display("FAIL %s_count: got beats=%0d reads=%0d done=%0d expected 30/30/1", name, beat, rd_next, done);
    end
    tick(1'b1, 1'b0, 1'b1);
    vectors++;
    if (rdy_in !== 1'b1 || out_val !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_end: got rdy_in=%b out_val=%b expected 1/0", name, rdy_in, out_val);
    end
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b0, 1'b1);
      vectors++;
      if (result_rden !== 4'h0 || out_val !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_extra_frame: got rden=%h out_val=%b expected 0/0", name, result_rden, out_val);
      end
    end
  endtask

  task automatic test_reset_mid();
    int beat;
    beat = 0;
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    for (int cyc = 0; cyc < 100; cyc++) begin
      tick(1'b1, 1'b0, 1'b1);
      if (out_val && beat == 10) break;
      if (out_val && out_rdy) beat++;
    end
    vectors++;
    if (beat != 10 || out_data !== exp_col(10)) begin
      miscompares++;
      $display("FAIL mid_reach: got beat=%0d data=%h expected 10/%h", beat, out_data, exp_col(10));
    end
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    vectors++;
    if (out_val !== 1'b0 || rdy_in !== 1'b1 || result_rden !== 4'h0 || out_data !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_reset: got val=%b rdy_in=%b rden=%h data=%h expected 0/1/0/0", out_val, rdy_in, result_rden, out_data);
    end
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b0, 1'b1);
      vectors++;
      if (out_val !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_stale_beat: got out_val=%b expected 0", out_val);
      end
    end
    test_frame("restart", 0);
  endtask

  task automatic test_relu();
    logic [31:0] want;
    mem[0][5] = 8'h80;
    mem[1][5] = 8'hFF;
    mem[2][5] = 8'h7F;
    mem[3][5] = 8'h00;
`ifdef CONV_RESULT_RD_RELU_EN
    want = 32'h007F_0000;
`else
    want = 32'h007F_FF80;
`endif
    col5 = 32'hDEAD_BEEF;
    test_frame("relu", 0);
    vectors++;
    if (col5 !== want) begin
      miscompares++;
      $display("FAIL relu_lanes: got %h expected %h", col5, want);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 4; i++)
      for (int a = 0; a < 32; a++)
        mem[i][a] = 8'(i*64 + a);
    reset = 1'b0;
    val_in = 1'b0;
    out_rdy = 1'b0;
    test_reset();
    test_frame("stream", 0);
    test_frame("toggle", 1);
    test_frame("stall", 2);
    test_frame("val_pulse", 3);
    test_reset_mid();
    test_relu();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
